// File: rtl/pid_coef_pkg.sv
// Shared constants and types for the PID coefficient loader.
// COEF_W here is the default width; the modules carry their own override.
package pid_coef_pkg;
  localparam int COEF_W   = 35;
  localparam int DATA_W   = 48;
  localparam int NUM_COEF = 6;

  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_COMMIT = 4'h2;
  localparam logic [3:0] OP_CLRERR = 4'h3;
  localparam logic [3:0] OP_OFF    = 4'h4;

  localparam logic [2:0] IDX_A1_PD = 3'd0;
  localparam logic [2:0] IDX_B0_PD = 3'd1;
  localparam logic [2:0] IDX_B1_PD = 3'd2;
  localparam logic [2:0] IDX_A1_PI = 3'd3;
  localparam logic [2:0] IDX_B0_PI = 3'd4;
  localparam logic [2:0] IDX_B1_PI = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_D0, S_D1, S_D2, S_APPLY, S_COMMIT
  } state_t;
endpackage

// File: rtl/pid_coef_bank.sv
// Shadow/active coefficient storage: frames land in shadow, commit copies
// all six to active on one edge so the filters never see a mixed set.
module pid_coef_bank import pid_coef_pkg::*; #(
  parameter int COEF_W = pid_coef_pkg::COEF_W
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             we,
  input  logic [2:0]                       idx,
  input  logic [COEF_W-1:0]                wval,
  input  logic                             commit,
  output logic [NUM_COEF-1:0][COEF_W-1:0]  active
);
  logic [NUM_COEF-1:0][COEF_W-1:0] shadow;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shadow <= '0;
      active <= '0;
    end else begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if (we && idx == 3'(i)) shadow[i] <= wval;
        if (commit)             active[i] <= shadow[i];
      end
    end
  end
endmodule

// File: rtl/pid_coef_loader.sv
// Host word-stream decoder loading six signed PID coefficients through a
// shadow bank, with commit, servo enable, timeout and sticky error.
module pid_coef_loader import pid_coef_pkg::*; #(
  parameter int COEF_W  = pid_coef_pkg::COEF_W,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [15:0]       wr_data_in,
  input  logic              wr_valid_in,
  output logic              wr_ready_out,
  output logic [COEF_W-1:0] a1_PD_out,
  output logic [COEF_W-1:0] b0_PD_out,
  output logic [COEF_W-1:0] b1_PD_out,
  output logic [COEF_W-1:0] a1_PI_out,
  output logic [COEF_W-1:0] b0_PI_out,
  output logic [COEF_W-1:0] b1_PI_out,
  output logic              on_out,
  output logic              update_out,
  output logic              err_out
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                          state;
  logic [CNT_W-1:0]                idle_cnt;
  logic [2:0]                      idx_q;
  logic [DATA_W-1:0]               data_q;
  logic [NUM_COEF-1:0][COEF_W-1:0] active;

  logic              xfer, hdr, in_frame, tmo, fits, idx_ok, op_known;
  logic              err_set, err_clr, bank_we, bank_commit;
  logic [3:0]        op;
  logic [DATA_W-COEF_W:0] upper;
  logic              unused_hdr;

  assign xfer        = wr_valid_in & wr_ready_out;
  assign op          = wr_data_in[15:12];
  assign unused_hdr  = ^wr_data_in[11:3];
  assign hdr         = (state == S_IDLE) & xfer;
  assign op_known    = op inside {OP_WRITE, OP_COMMIT, OP_CLRERR, OP_OFF};
  assign in_frame    = state inside {S_D0, S_D1, S_D2};
  assign tmo         = in_frame & ~xfer & (idle_cnt == CNT_W'(TIMEOUT - 1));

  // Value fits COEF_W signed bits when everything from the target sign bit up is a copy of it
  assign upper       = data_q[DATA_W-1:COEF_W-1];
  assign fits        = (&upper) | ~(|upper);
  assign idx_ok      = idx_q <= IDX_B1_PI;

  assign err_set     = (hdr & ~op_known) | tmo | ((state == S_APPLY) & ~(fits & idx_ok));
  assign err_clr     = hdr & (op == OP_CLRERR);
  assign bank_we     = (state == S_APPLY) & fits & idx_ok;
  assign bank_commit = (state == S_COMMIT);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= S_IDLE;
      wr_ready_out <= 1'b0;
      idle_cnt     <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      on_out       <= 1'b0;
      update_out   <= 1'b0;
      err_out      <= 1'b0;
    end else begin
      wr_ready_out <= 1'b1;
      update_out   <= (state == S_COMMIT);
      if (err_set)      err_out <= 1'b1;
      else if (err_clr) err_out <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (xfer) begin
            case (op)
              OP_WRITE: begin
                state    <= S_D0;
                idx_q    <= wr_data_in[2:0];
                idle_cnt <= '0;
              end
              OP_COMMIT: begin
                state        <= S_COMMIT;
                wr_ready_out <= 1'b0;
              end
              OP_OFF:  on_out <= 1'b0;
              default: ;
            endcase
          end
        end
        S_D0, S_D1, S_D2: begin
          if (xfer) begin
            data_q   <= {data_q[DATA_W-17:0], wr_data_in};
            idle_cnt <= '0;
            if (state == S_D0)      state <= S_D1;
            else if (state == S_D1) state <= S_D2;
            else begin
              state        <= S_APPLY;
              wr_ready_out <= 1'b0;
            end
          end else if (tmo) begin
            state    <= S_IDLE;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_APPLY:  state <= S_IDLE;
        S_COMMIT: begin
          state  <= S_IDLE;
          on_out <= 1'b1;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  pid_coef_bank #(.COEF_W(COEF_W)) u_bank (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .we       (bank_we),
    .idx      (idx_q),
    .wval     (data_q[COEF_W-1:0]),
    .commit   (bank_commit),
    .active   (active)
  );

  assign a1_PD_out = active[IDX_A1_PD];
  assign b0_PD_out = active[IDX_B0_PD];
  assign b1_PD_out = active[IDX_B1_PD];
  assign a1_PI_out = active[IDX_A1_PI];
  assign b0_PI_out = active[IDX_B0_PI];
  assign b1_PI_out = active[IDX_B1_PI];
endmodule

// File: tb/tb_pid_coef_loader.sv
// Scoreboarded bench for pid_coef_loader: directed scenarios plus random
// command streams against an arithmetic model of the coefficient sets.
module tb_pid_coef_loader;
  localparam int CW  = 35;
  localparam int TMO = 1023;
  typedef logic [5:0][CW-1:0] set_t;

  logic          clk_in = 1'b0, rst_n_in = 1'b0, wr_valid_in = 1'b0;
  logic [15:0]   wr_data_in = '0;
  logic          wr_ready_out, on_out, update_out, err_out;
  logic [CW-1:0] a1_PD_out, b0_PD_out, b1_PD_out, a1_PI_out, b0_PI_out, b1_PI_out;

  pid_coef_loader #(.COEF_W(CW), .TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .wr_data_in(wr_data_in),
    .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
    .a1_PD_out(a1_PD_out), .b0_PD_out(b0_PD_out), .b1_PD_out(b1_PD_out),
    .a1_PI_out(a1_PI_out), .b0_PI_out(b0_PI_out), .b1_PI_out(b1_PI_out),
    .on_out(on_out), .update_out(update_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int            checks = 0, errors = 0;
  logic [CW-1:0] sh_m [6];
  logic [CW-1:0] act_m[6];
  logic          on_m, err_m;
  set_t          exp_q[$];
  set_t          mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic set_t cur();
    return {b1_PI_out, b0_PI_out, a1_PI_out, b1_PD_out, b0_PD_out, a1_PD_out};
  endfunction

  // Monitor: every update pulse must present the oldest committed shadow set
  always @(negedge clk_in) begin
    if (rst_n_in && update_out) begin
      if (exp_q.size() == 0) chk("update_unexpected", {63'd0, update_out}, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        for (int i = 0; i < 6; i++)
          chk($sformatf("commit_set[%0d]", i), 64'(cur()[i]), 64'(mon_e[i]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    wr_data_in  = w;
    wr_valid_in = 1'b1;
    while (!wr_ready_out && n < 20) begin @(negedge clk_in); n++; end
    if (!wr_ready_out) begin
      chk("ready_wait", {63'd0, wr_ready_out}, 64'd1);
      wr_valid_in = 1'b0;
      return;
    end
    @(negedge clk_in);
    wr_valid_in = 1'b0;
    wr_data_in  = 16'($urandom);
  endtask

  task automatic check_all(input string tag, input logic exp_rdy);
    set_t g = cur();
    for (int i = 0; i < 6; i++) chk($sformatf("%s.coef%0d", tag, i), 64'(g[i]), 64'(act_m[i]));
    chk({tag, ".on"},     {63'd0, on_out},       {63'd0, on_m});
    chk({tag, ".err"},    {63'd0, err_out},      {63'd0, err_m});
    chk({tag, ".update"}, {63'd0, update_out},   64'd0);
    chk({tag, ".ready"},  {63'd0, wr_ready_out}, {63'd0, exp_rdy});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) begin sh_m[i] = '0; act_m[i] = '0; end
    on_m = 1'b0; err_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    wr_valid_in = 1'b0;
    rst_n_in    = 1'b0;
    model_clear();
    @(negedge clk_in);
    check_all("in_reset", 1'b0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("ready_after_reset", {63'd0, wr_ready_out}, 64'd1);
  endtask

  // Model: the 48-bit word is a signed integer; it is stored only if it fits CW signed bits
  task automatic model_write(input logic [2:0] idx, input logic [47:0] v);
    longint s   = longint'($signed(v));
    longint lim = longint'(1) << (CW - 1);
    if (idx <= 3'd5 && s >= -lim && s < lim) sh_m[idx] = v[CW-1:0];
    else err_m = 1'b1;
  endtask

  task automatic write_frame(input logic [2:0] idx, input logic [47:0] v);
    send({4'h1, 9'($urandom), idx});
    send(v[47:32]); send(v[31:16]); send(v[15:0]);
    model_write(idx, v);
    idle(2);
  endtask

  task automatic commit();
    set_t e;
    for (int i = 0; i < 6; i++) e[i] = sh_m[i];
    exp_q.push_back(e);
    send({4'h2, 12'($urandom)});
    @(negedge clk_in); chk("update_latency", {63'd0, update_out}, 64'd1);
    @(negedge clk_in); chk("update_single",  {63'd0, update_out}, 64'd0);
    for (int i = 0; i < 6; i++) act_m[i] = sh_m[i];
    on_m = 1'b1;
  endtask

  task automatic clrerr();
    send({4'h3, 12'($urandom)}); err_m = 1'b0; idle(1);
  endtask

  task automatic off();
    send({4'h4, 12'($urandom)}); on_m = 1'b0; idle(1);
  endtask

  task automatic bad_op();
    logic [3:0] op = 4'($urandom_range(0, 11));
    if (op != 0) op = op + 4'd4;
    send({op, 12'($urandom)}); err_m = 1'b1; idle(1);
  endtask

  function automatic logic [47:0] rand_val();
    longint lim = longint'(1) << (CW - 1);
    longint b[4];
    b[0] = lim - 1; b[1] = -lim; b[2] = lim; b[3] = -lim - 1;
    case ($urandom_range(0, 4))
      0:       return 48'({$urandom, $urandom});
      1:       return 48'(longint'($signed($urandom)));
      2:       return 48'(b[$urandom_range(0, 3)]);
      3:       return 48'(longint'($urandom_range(0, 1000)));
      default: return 48'(-longint'($urandom_range(1, 1000)));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(negedge clk_in);
    do_reset();
    check_all("post_reset", 1'b1);

    write_frame(3'd1, 48'h000000004000);
    commit();
    check_all("b0pd_4000", 1'b1);

    write_frame(3'd0, 48'hFFFFFFFFFFFF);
    check_all("write_no_commit", 1'b1);
    commit();
    check_all("a1pd_minus1", 1'b1);

    write_frame(3'd2, 48'h000400000000);
    check_all("out_of_range", 1'b1);
    clrerr();
    check_all("clrerr", 1'b1);

    // Just inside the idle window the frame still completes
    send({4'h1, 12'd3});
    idle(TMO - 1);
    send(16'hFFFF); send(16'hFFFF); send(16'hFF80);
    model_write(3'd3, 48'hFFFFFFFFFF80);
    idle(2);
    commit();
    check_all("tmo_edge_ok", 1'b1);

    send({4'h1, 12'd4});
    send(16'h0000);
    idle(TMO - 1);
    chk("tmo_not_yet", {63'd0, err_out}, 64'd0);
    idle(1);
    err_m = 1'b1;
    check_all("timeout", 1'b1);
    commit();
    check_all("commit_after_tmo", 1'b1);
    clrerr();

    write_frame(3'd7, 48'h000000000123);
    check_all("idx7", 1'b1);
    clrerr();
    off();
    check_all("off", 1'b1);
    bad_op();
    check_all("bad_op", 1'b1);
    clrerr();

    send({4'h1, 12'd3});
    send(16'h0000);
    do_reset();
    check_all("reset_mid_frame", 1'b1);
    write_frame(3'd5, 48'h000000012345);
    commit();
    check_all("after_reset_frame", 1'b1);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: write_frame(3'($urandom_range(0, 7)), rand_val());
        4, 5:       commit();
        6:          clrerr();
        7:          off();
        default:    bad_op();
      endcase
      idle($urandom_range(0, 2));
      check_all($sformatf("rand%0d", n), 1'b1);
    end

    idle(4);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
